// File: rtl/vga_pkg.sv
// Shared VGA coordinate type and default 640x480@60 timing constants.
package vga_pkg;

  localparam int unsigned COORD_W = 11;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with wrap, visible and sync flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned FP      = H_FP_DEF,
  parameter int unsigned SYNC    = H_SYNC_DEF,
  parameter int unsigned BP      = H_BP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  output coord_t count,
  output logic   wrap_c,
  output logic   visible_c,
  output logic   sync_c
);

  localparam int unsigned TOTAL   = VISIBLE + FP + SYNC + BP;
  localparam coord_t      LAST    = COORD_W'(TOTAL - 1);
  localparam coord_t      VIS_END = COORD_W'(VISIBLE);
  localparam coord_t      SYNC_LO = COORD_W'(VISIBLE + FP);
  localparam coord_t      SYNC_HI = COORD_W'(VISIBLE + FP + SYNC);

  coord_t count_next_c;

  assign wrap_c = (count == LAST);

  always_comb begin
    count_next_c = count;
    if (step) begin
      count_next_c = wrap_c ? '0 : count + COORD_W'(1);
    end
  end

  // Visibility looks through a pending step so the caller sees the value about to be entered.
  assign visible_c = (count_next_c < VIS_END);
  assign sync_c    = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/vga_sync_blank_gen.sv
// VGA timing generator: pixel strobe, H/V counters, pixel requests, delayed syncs and blanked colour.
module vga_sync_blank_gen
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COLOR_W-1:0] vram_red,
  input  logic [COLOR_W-1:0] vram_green,
  input  logic [COLOR_W-1:0] vram_blue,
  output coord_t             pixel_x,
  output coord_t             pixel_y,
  output logic               pixel_req,
  output logic               frame_start,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE
);

  localparam int unsigned      DIV_W     = 5;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic             SYNC_IDLE = ~SYNC_POL;

  logic [DIV_W-1:0] div_cnt;
  logic strobe_c, h_step_c, v_step_c, vis_c;
  logic primed;
  logic h_wrap_c, h_vis_c, h_sync_c;
  logic v_wrap_c, v_vis_c, v_sync_c;
  logic blank_q, req_d, blank_d, hs_q, vs_q;

  assign strobe_c = enable && (div_cnt == DIV_LAST);
  // The first strobe after reset enters pixel (0,0) instead of advancing past it.
  assign h_step_c = strobe_c && primed;
  assign v_step_c = h_step_c && h_wrap_c;
  assign vis_c    = h_vis_c && v_vis_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      primed  <= 1'b0;
    end else if (enable) begin
      div_cnt <= strobe_c ? '0 : div_cnt + DIV_W'(1);
      if (strobe_c) begin
        primed <= 1'b1;
      end
    end
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .reset(reset), .step(h_step_c), .count(pixel_x),
    .wrap_c(h_wrap_c), .visible_c(h_vis_c), .sync_c(h_sync_c)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .reset(reset), .step(v_step_c), .count(pixel_y),
    .wrap_c(v_wrap_c), .visible_c(v_vis_c), .sync_c(v_sync_c)
  );

  // Pixel entry events and their one-clk-delayed copies that steer the colour load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_req   <= 1'b0;
      frame_start <= 1'b0;
      blank_q     <= 1'b0;
      req_d       <= 1'b0;
      blank_d     <= 1'b0;
    end else begin
      pixel_req   <= strobe_c && vis_c;
      blank_q     <= strobe_c && !vis_c;
      frame_start <= h_step_c && h_wrap_c && v_wrap_c;
      req_d       <= pixel_req;
      blank_d     <= blank_q;
    end
  end

  // Two-stage sync delay keeps the syncs aligned with the colour registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      VGA_HSYNC <= SYNC_IDLE;
      VGA_VSYNC <= SYNC_IDLE;
    end else if (!enable) begin
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      VGA_HSYNC <= SYNC_IDLE;
      VGA_VSYNC <= SYNC_IDLE;
    end else begin
      hs_q      <= h_sync_c ? SYNC_POL : SYNC_IDLE;
      vs_q      <= v_sync_c ? SYNC_POL : SYNC_IDLE;
      VGA_HSYNC <= hs_q;
      VGA_VSYNC <= vs_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
    end else if (enable && req_d) begin
      VGA_RED   <= vram_red;
      VGA_GREEN <= vram_green;
      VGA_BLUE  <= vram_blue;
    end else if (!enable || blank_d) begin
      VGA_RED   <= '0;
      VGA_GREEN <= '0;
      VGA_BLUE  <= '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_blank_gen.sv
// Scoreboard bench for vga_sync_blank_gen on a small 14x8 raster with CLK_DIV=2.
module tb_vga_sync_blank_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 1, HT = HV + HF + HS + HB;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int D  = 2;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  vram_red = '0, vram_green = '0, vram_blue = '0;
  logic [10:0] pixel_x, pixel_y;
  logic        pixel_req, frame_start, VGA_HSYNC, VGA_VSYNC;
  logic [3:0]  VGA_RED, VGA_GREEN, VGA_BLUE;

  vga_sync_blank_gen #(
    .COLOR_W(4), .CLK_DIV(D),
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vram_red(vram_red), .vram_green(vram_green), .vram_blue(vram_blue),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
    .frame_start(frame_start), .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
    .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y;
    bit req, fs, hs, vs, entry, vis;
    int r, g, b;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: enabled-cycle count since reset and the last two expected samples.
  exp_t cur, prv;
  int   ne = 0;
  bit   en_prev = 1'b0;
  bit   fixed_a = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.x = 0; e.y = 0; e.req = 0; e.fs = 0; e.hs = 1; e.vs = 1;
    e.entry = 0; e.vis = 0; e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
  task automatic drive(input bit rst, input bit en);
    exp_t nxt;
    bit   was_high;
    bit   strobe;
    int   s;
    @(negedge clk);
    was_high   = reset;
    reset      = rst;
    enable     = en;
    vram_red   = fixed_a ? 4'hA : 4'($urandom);
    vram_green = fixed_a ? 4'hA : 4'($urandom);
    vram_blue  = fixed_a ? 4'hA : 4'($urandom);
    if (!rst) begin
      nxt = idle_rec();
      prv = nxt; cur = nxt; ne = 0; en_prev = 0;
    end else begin
      if (en) ne++;
      strobe    = en && (ne % D == 0);
      s         = ne / D;
      nxt.x     = (s == 0) ? 0 : (s - 1) % HT;
      nxt.y     = (s == 0) ? 0 : ((s - 1) / HT) % VT;
      nxt.vis   = (nxt.x < HV) && (nxt.y < VV);
      nxt.entry = strobe;
      nxt.req   = strobe && nxt.vis;
      nxt.fs    = strobe && (s > 1) && ((s - 1) % (HT * VT) == 0);
      nxt.hs    = !(en && en_prev && prv.x >= HV + HF && prv.x < HV + HF + HS);
      nxt.vs    = !(en && en_prev && prv.y >= VV + VF && prv.y < VV + VF + VS);
      if (!en) begin
        nxt.r = 0; nxt.g = 0; nxt.b = 0;
      end else if (prv.req) begin
        nxt.r = int'(vram_red); nxt.g = int'(vram_green); nxt.b = int'(vram_blue);
      end else if (prv.entry) begin
        nxt.r = 0; nxt.g = 0; nxt.b = 0;
      end else begin
        nxt.r = cur.r; nxt.g = cur.g; nxt.b = cur.b;
      end
      prv = cur; cur = nxt; en_prev = en;
    end
    exp_q.push_back(nxt);
    if (was_high && !rst) begin
      #1;
      chk("async_pixel_x", int'(pixel_x), 0);
      chk("async_pixel_y", int'(pixel_y), 0);
      chk("async_pixel_req", int'(pixel_req), 0);
      chk("async_frame_start", int'(frame_start), 0);
      chk("async_hsync", int'(VGA_HSYNC), 1);
      chk("async_vsync", int'(VGA_VSYNC), 1);
      chk("async_colour", int'({VGA_RED, VGA_GREEN, VGA_BLUE}), 0);
    end
  endtask

  task automatic run_to_pixel(input int x, input int y);
    int n = 0;
    do begin
      drive(1'b1, 1'b1);
      n++;
    end while (!(cur.entry && cur.x == x && cur.y == y) && n < 2000);
    if (n >= 2000) begin
      n_bad++;
      $display("FAIL reach_pixel: pixel (%0d,%0d) not reached in %0d cycles", x, y, n);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   clean = 0, since_fs = 0, reqs = 0, hs_run = 0, vs_run = 0;
    bit   seen_fs = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("pixel_x", int'(pixel_x), e.x);
        chk("pixel_y", int'(pixel_y), e.y);
        chk("pixel_req", int'(pixel_req), int'(e.req));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("VGA_HSYNC", int'(VGA_HSYNC), int'(e.hs));
        chk("VGA_VSYNC", int'(VGA_VSYNC), int'(e.vs));
        chk("VGA_RED", int'(VGA_RED), e.r);
        chk("VGA_GREEN", int'(VGA_GREEN), e.g);
        chk("VGA_BLUE", int'(VGA_BLUE), e.b);
      end
      if (!VGA_HSYNC || !VGA_VSYNC)
        chk("colour_during_sync", int'({VGA_RED, VGA_GREEN, VGA_BLUE}), 0);

      // Frame-level timing over uninterrupted stretches.
      if (reset && enable) clean++;
      else begin
        clean = 0;
        seen_fs = 0;
      end
      since_fs++;
      if (frame_start) begin
        if (seen_fs && clean > 240) begin
          chk("frame_period_clk", since_fs, 224);
          chk("pixel_req_per_frame", reqs, 32);
        end
        seen_fs = 1; since_fs = 0; reqs = 0;
      end
      if (pixel_req) reqs++;
      if (!VGA_HSYNC) hs_run++;
      else begin
        if (hs_run > 0 && clean > hs_run + 8) chk("hsync_low_clk", hs_run, 6);
        hs_run = 0;
      end
      if (!VGA_VSYNC) vs_run++;
      else begin
        if (vs_run > 0 && clean > vs_run + 8) chk("vsync_low_clk", vs_run, 56);
        vs_run = 0;
      end
    end
  end

  initial begin : stimulus
    cur = idle_rec();
    prv = cur;
    repeat (3) drive(1'b0, 1'b1);
    repeat (700) drive(1'b1, 1'b1);
    run_to_pixel(3, 2);
    repeat (10) drive(1'b1, 1'b0);
    repeat (300) drive(1'b1, 1'b1);
    fixed_a = 1'b0;
    repeat (500) drive(1'b1, $urandom_range(0, 3) != 0);
    run_to_pixel(12, 6);
    repeat (3) drive(1'b0, 1'b1);
    repeat (300) drive(1'b1, 1'b1);
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_blank_gen.md
VGA_SYNC_BLANK_GEN -- requirements
Module: vga_sync_blank_gen

Interface
REQ-001 Parameter COLOR_W, default 4: bits per colour channel.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per pixel; the legal range is 1..16.
REQ-003 Parameters H_VISIBLE, H_FP, H_SYNC, H_BP have defaults 640, 16, 96, 48; they give the horizontal timing in pixels.
REQ-004 Parameters V_VISIBLE, V_FP, V_SYNC, V_BP have defaults 480, 10, 2, 33; they give the vertical timing in lines.
REQ-005 Parameter SYNC_POL, default 0: the active level of HSYNC and VSYNC (0 means active-low).
REQ-006 clk  input  1  system clock; the block uses one clock only.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  run/hold control for the timing engine.
REQ-009 vram_red, vram_green, vram_blue  input  COLOR_W each  pixel data from VRAM; valid 1 clk after pixel_req.
REQ-010 pixel_x, pixel_y  output  11 each  registered coordinates of the current pixel.
REQ-011 pixel_req  output  1  one-clk pulse when (pixel_x, pixel_y) is a visible pixel.
REQ-012 frame_start  output  1  one-clk pulse at pixel (0,0).
REQ-013 VGA_HSYNC, VGA_VSYNC  output  1 each  registered sync outputs.
REQ-014 VGA_RED, VGA_GREEN, VGA_BLUE  output  COLOR_W each  registered colour outputs.

Function
REQ-015 A strobe counter shall count 0..CLK_DIV-1 while enable=1; the pixel strobe is the cycle in which the count equals CLK_DIV-1.
REQ-016 On each strobe, hcount shall increment, wrapping from H_TOTAL-1 to 0 (H_TOTAL = sum of the four H parameters).
REQ-017 On each hcount wrap, vcount shall increment, wrapping from V_TOTAL-1 to 0 (V_TOTAL defined likewise).
REQ-018 pixel_x and pixel_y shall equal hcount and vcount.
REQ-019 visible = (hcount < H_VISIBLE) and (vcount < V_VISIBLE).
REQ-020 pixel_req shall pulse for 1 clk in the cycle after each strobe whose new counter values are visible.
REQ-021 The colour registers shall load the vram inputs 1 clk after pixel_req and hold them until the next pixel's load.
REQ-022 The colour registers shall load 0 at the first pixel whose visible=0 and hold 0 for every non-visible pixel.
REQ-023 HSYNC shall be active while H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC.
REQ-024 VSYNC shall be active while V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC.
REQ-025 HSYNC and VSYNC shall be delayed by 2 clk so that they stay aligned with the colour outputs.
REQ-026 frame_start shall pulse for 1 clk when the counters wrap to (0,0).
REQ-027 When enable=0, all counters shall hold.
REQ-028 When enable=0, pixel_req and frame_start shall be 0, the syncs shall be at the inactive level and the colours shall be 0.
REQ-029 When enable rises again, counting shall resume from the held values with no spurious pulse.
REQ-030 Simultaneous hcount wrap and vcount wrap shall yield exactly one frame_start.
REQ-031 The colour outputs shall never be non-zero while either sync is active.

Reset
REQ-032 reset=0 shall clear all counters, pixel_x, pixel_y, pixel_req, frame_start and the colour outputs to 0 immediately and independently of clk.
REQ-033 During reset, the syncs shall be at the inactive level (~SYNC_POL).
REQ-034 After reset release, the first strobe shall occur CLK_DIV clk cycles later.
REQ-035 After reset release, the first pixel shall be (0,0); frame_start shall not pulse for this first frame.
REQ-036 Reset asserted mid-line or mid-frame shall abort the current frame with no glitch on the sync outputs.

Structure
REQ-037 Package vga_pkg shall hold COORD_W=11 and the default 640x480@60 timing constants.
REQ-038 Sub-module vga_axis_counter (parameters VISIBLE, FP, SYNC, BP) shall be instantiated twice, once for each axis.
REQ-039 vga_axis_counter shall provide the count, the wrap flag, the visible flag and the sync flag.

Verification
Bench parameters: H = 8/2/3/1 (H_TOTAL=14), V = 4/1/2/1 (V_TOTAL=8), CLK_DIV=2, COLOR_W=4, SYNC_POL=0.
REQ-040 Release reset and hold enable=1 -> frame_start pulses every 224 clk; pixel_req pulses 32 times per frame.
REQ-041 Observe VGA_HSYNC -> low for 6 clk once per 28-clk line, beginning 2 clk after hcount reaches 10.
REQ-042 Observe VGA_VSYNC -> low for exactly 2 lines (56 clk) per frame, covering vcount 5..6 plus the 2-clk delay.
REQ-043 Drive vram with 4'hA constantly -> colours show 4'hA only for visible pixels and 0 elsewhere, including whenever a sync is active.
REQ-044 Drop enable for 10 clk at pixel (3,2) -> outputs idle, pixel_x=3 and pixel_y=2 hold, and counting resumes with no extra frame_start.
REQ-045 Assert reset at pixel (12,6) -> all outputs reach reset values before the next clk edge; after release the first pixel_req corresponds to (0,0).
